inst_fetch_unit: RTL and testbench

- Sits directly downstream of the PC calculator in the multi-cycle MIPS datapath.
- Takes the current pc, issues one read per fetch over the request/address/data handshake to instruction memory, and latches the returned word into the instruction register.
- The instruction register drives decode and feeds the instruction input of the PC calculator.
- Reports misaligned fetch (AdEL) and bus timeout to the exception logic.

---
 rtl/inst_fetch_unit_pkg.sv | 19 +
 rtl/inst_fetch_unit_timeout_counter.sv | 34 +++
 rtl/inst_fetch_unit.sv | 132 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch path: state encoding, reset vector
// and the exception code the fetch unit raises.
package inst_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } fetch_state_e;

  localparam logic [31:0] RESET_VECTOR = 32'hbfc00000;
  localparam logic [4:0]  EXC_ADEL     = 5'h04;

  // Instruction fetches must be word aligned; anything else raises AdEL.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_unit_timeout_counter.sv
// Bus watchdog for one fetch: counts busy cycles and flags the last allowed one.
module fetch_timeout_counter (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] limit,
  output logic       expired
);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_q + 8'd1;
    end
  end

  // NOTE: state flops use <= so every flop samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired = enable && (count_q == limit - 8'd1);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: one memory read per fetch_start, result held in the
// instruction register; reports AdEL on misaligned pc and a bus timeout.
module inst_fetch_unit
  import inst_fetch_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] RESET_INST     = 32'h00000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        fetch_start,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic [31:0] inst_rdata,
  input  logic        inst_data_ok,
  output logic [31:0] instruction,
  output logic        fetch_done,
  output logic        fetch_busy,
  output logic        adel_ex,
  output logic        bus_err,
  output logic [31:0] bad_vaddr
);

  localparam logic [7:0] TIMER_LIMIT = 8'(TIMEOUT_CYCLES);

  fetch_state_e state_q, state_d;
  logic [31:0]  inst_addr_q, inst_addr_d;
  logic [31:0]  instruction_q, instruction_d;
  logic [31:0]  bad_vaddr_q, bad_vaddr_d;
  logic         fetch_done_q, fetch_done_d;
  logic         adel_ex_q, adel_ex_d;
  logic         bus_err_q, bus_err_d;
  logic         timer_clear;
  logic         timer_expired;

  assign fetch_busy = (state_q == ST_REQ) || (state_q == ST_WAIT);

  fetch_timeout_counter u_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (timer_clear),
    .enable  (fetch_busy),
    .limit   (TIMER_LIMIT),
    .expired (timer_expired)
  );

  // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    inst_addr_d   = inst_addr_q;
    instruction_d = instruction_q;
    bad_vaddr_d   = bad_vaddr_q;
    fetch_done_d  = 1'b0;
    adel_ex_d     = 1'b0;
    bus_err_d     = 1'b0;
    timer_clear   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (fetch_start) begin
          if (is_misaligned(pc)) begin
            adel_ex_d   = 1'b1;
            bad_vaddr_d = pc;
          end else begin
            inst_addr_d = pc;
            timer_clear = 1'b1;
            state_d     = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // Completion is tested before the timer so a reply on the last cycle still lands.
        if (inst_addr_ok && inst_data_ok) begin
          instruction_d = inst_rdata;
          fetch_done_d  = 1'b1;
          state_d       = ST_IDLE;
        end else if (timer_expired) begin
          bus_err_d   = 1'b1;
          bad_vaddr_d = inst_addr_q;
          state_d     = ST_IDLE;
        end else if (inst_addr_ok) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (inst_data_ok) begin
          instruction_d = inst_rdata;
          fetch_done_d  = 1'b1;
          state_d       = ST_IDLE;
        end else if (timer_expired) begin
          bus_err_d   = 1'b1;
          bad_vaddr_d = inst_addr_q;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: synchronous reset of every register, including the instruction register,
  // so a fetch abandoned by reset can never leave a stale word behind.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_IDLE;
      inst_addr_q   <= '0;
      instruction_q <= RESET_INST;
      bad_vaddr_q   <= '0;
      fetch_done_q  <= 1'b0;
      adel_ex_q     <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      inst_addr_q   <= inst_addr_d;
      instruction_q <= instruction_d;
      bad_vaddr_q   <= bad_vaddr_d;
      fetch_done_q  <= fetch_done_d;
      adel_ex_q     <= adel_ex_d;
      bus_err_q     <= bus_err_d;
    end
  end

  assign inst_req    = (state_q == ST_REQ);
  assign inst_addr   = inst_addr_q;
  assign instruction = instruction_q;
  assign bad_vaddr   = bad_vaddr_q;
  assign fetch_done  = fetch_done_q;
  assign adel_ex     = adel_ex_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: per-cycle vector table plus hand-written
// sequences for reset during WAIT and back-to-back fetches.
module tb_inst_fetch_unit;
  import inst_fetch_unit_pkg::*;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        fetch_start;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic [31:0] inst_rdata;
  logic        inst_data_ok;
  logic [31:0] instruction;
  logic        fetch_done;
  logic        fetch_busy;
  logic        adel_ex;
  logic        bus_err;
  logic [31:0] bad_vaddr;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  inst_fetch_unit #(
    .TIMEOUT_CYCLES (TO),
    .RESET_INST     (32'h00000000)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pc           (pc),
    .fetch_start  (fetch_start),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_rdata   (inst_rdata),
    .inst_data_ok (inst_data_ok),
    .instruction  (instruction),
    .fetch_done   (fetch_done),
    .fetch_busy   (fetch_busy),
    .adel_ex      (adel_ex),
    .bus_err      (bus_err),
    .bad_vaddr    (bad_vaddr)
  );

  typedef struct {
    string       tag;
    logic        rst;
    logic        start;
    logic [31:0] pc;
    logic        aok;
    logic        dok;
    logic [31:0] rdata;
    logic        req;
    logic [31:0] addr;
    logic [31:0] inst;
    logic        done;
    logic        busy;
    logic        adel;
    logic        berr;
    logic [31:0] bad;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic start, input logic [31:0] p,
                       input logic aok, input logic dok, input logic [31:0] rdata);
    reset        = rst;
    fetch_start  = start;
    pc           = p;
    inst_addr_ok = aok;
    inst_data_ok = dok;
    inst_rdata   = rdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void add(input string tag, input logic rst, input logic start,
                              input logic [31:0] p, input logic aok, input logic dok,
                              input logic [31:0] rdata, input logic req,
                              input logic [31:0] addr, input logic [31:0] inst,
                              input logic done, input logic busy, input logic adel,
                              input logic berr, input logic [31:0] bad);
    vec_t v;
    v.tag = tag;  v.rst = rst;   v.start = start; v.pc = p;
    v.aok = aok;  v.dok = dok;   v.rdata = rdata; v.req = req;
    v.addr = addr; v.inst = inst; v.done = done;  v.busy = busy;
    v.adel = adel; v.berr = berr; v.bad = bad;
    vecs.push_back(v);
  endfunction

  task automatic check_all(input string tag, input logic req, input logic [31:0] addr,
                           input logic [31:0] inst, input logic done, input logic busy,
                           input logic adel, input logic berr, input logic [31:0] bad);
    check({tag, ".inst_req"},    32'(inst_req),   32'(req));
    check({tag, ".inst_addr"},   inst_addr,       addr);
    check({tag, ".instruction"}, instruction,     inst);
    check({tag, ".fetch_done"},  32'(fetch_done), 32'(done));
    check({tag, ".fetch_busy"},  32'(fetch_busy), 32'(busy));
    check({tag, ".adel_ex"},     32'(adel_ex),    32'(adel));
    check({tag, ".bus_err"},     32'(bus_err),    32'(berr));
    check({tag, ".bad_vaddr"},   bad_vaddr,       bad);
  endtask

  localparam logic [31:0] P2 = 32'h00400000;
  localparam logic [31:0] PM = 32'hbfc00002;
  localparam logic [31:0] P4 = 32'hbfc00010;
  localparam logic [31:0] I1 = 32'h3c1d8000;
  localparam logic [31:0] I2 = 32'h24020001;

  initial begin
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);

    // Expected values are the outputs just after the edge that consumed the inputs.
    add("rst",        0, 0, '0,           0, 0, '0,           0, '0,           '0, 0, 0, 0, 0, '0);
    // Fetch from the reset vector: addr_ok in the second REQ cycle, data_ok on the timer limit.
    add("t1_start",   1, 1, RESET_VECTOR, 0, 0, '0,           1, RESET_VECTOR, '0, 0, 1, 0, 0, '0);
    add("t1_req2",    1, 0, '0,           0, 0, '0,           1, RESET_VECTOR, '0, 0, 1, 0, 0, '0);
    add("t1_aok",     1, 0, '0,           1, 0, '0,           0, RESET_VECTOR, '0, 0, 1, 0, 0, '0);
    add("t1_wait",    1, 0, '0,           0, 0, '0,           0, RESET_VECTOR, '0, 0, 1, 0, 0, '0);
    add("t1_dok_lim", 1, 0, '0,           0, 1, I1,           0, RESET_VECTOR, I1, 1, 0, 0, 0, '0);
    add("t1_idle",    1, 0, '0,           0, 0, '0,           0, RESET_VECTOR, I1, 0, 0, 0, 0, '0);
    // Same-cycle addr_ok + data_ok: minimum latency.
    add("t2_start",   1, 1, P2,           0, 0, '0,           1, P2,           I1, 0, 1, 0, 0, '0);
    add("t2_same",    1, 0, '0,           1, 1, I2,           0, P2,           I2, 1, 0, 0, 0, '0);
    add("t2_idle_dok",1, 0, '0,           0, 1, 32'hffffffff, 0, P2,           I2, 0, 0, 0, 0, '0);
    // Misaligned pc.
    add("t3_adel",    1, 1, PM,           0, 0, '0,           0, P2,           I2, 0, 0, 1, 0, PM);
    add("t3_idle",    1, 0, '0,           0, 0, '0,           0, P2,           I2, 0, 0, 0, 0, PM);
    // Timeout with addr_ok never given.
    add("t4_start",   1, 1, P4,           0, 0, '0,           1, P4,           I2, 0, 1, 0, 0, PM);
    add("t4_req_a",   1, 0, '0,           0, 0, '0,           1, P4,           I2, 0, 1, 0, 0, PM);
    add("t4_req_b",   1, 0, '0,           0, 0, '0,           1, P4,           I2, 0, 1, 0, 0, PM);
    add("t4_req_c",   1, 0, '0,           0, 0, '0,           1, P4,           I2, 0, 1, 0, 0, PM);
    add("t4_timeout", 1, 0, '0,           0, 0, '0,           0, P4,           I2, 0, 0, 0, 1, P4);
    add("t4_idle",    1, 0, '0,           0, 0, '0,           0, P4,           I2, 0, 0, 0, 0, P4);

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].start, vecs[i].pc, vecs[i].aok, vecs[i].dok, vecs[i].rdata);
      tick();
      check_all(vecs[i].tag, vecs[i].req, vecs[i].addr, vecs[i].inst, vecs[i].done,
                vecs[i].busy, vecs[i].adel, vecs[i].berr, vecs[i].bad);
    end

    // Reset while in WAIT, then a late data_ok must not reach the instruction register.
    drive(1'b1, 1'b1, 32'hbfc00020, 1'b0, 1'b0, '0);
    tick();
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    tick();
    check_all("r_wait", 0, 32'hbfc00020, I2, 0, 1, 0, 0, P4);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
    tick();
    check_all("r_reset", 0, '0, '0, 0, 0, 0, 0, '0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'hdeadbeef);
    tick();
    check_all("r_late_dok", 0, '0, '0, 0, 0, 0, 0, '0);

    // Back-to-back fetches; a fetch_start during WAIT is dropped.
    drive(1'b1, 1'b1, RESET_VECTOR, 1'b0, 1'b0, '0);
    tick();
    check_all("b_start", 1, RESET_VECTOR, '0, 0, 1, 0, 0, '0);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
    tick();
    drive(1'b1, 1'b1, 32'h12345670, 1'b0, 1'b0, '0);
    tick();
    check_all("b_ignored", 0, RESET_VECTOR, '0, 0, 1, 0, 0, '0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b1, 32'h8fbf0010);
    tick();
    check_all("b_done1", 0, RESET_VECTOR, 32'h8fbf0010, 1, 0, 0, 0, '0);
    drive(1'b1, 1'b1, RESET_VECTOR + 32'd4, 1'b0, 1'b0, '0);
    tick();
    check_all("b_start2", 1, 32'hbfc00004, 32'h8fbf0010, 0, 1, 0, 0, '0);
    drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h27bdffe8);
    tick();
    check_all("b_done2", 0, 32'hbfc00004, 32'h27bdffe8, 1, 0, 0, 0, '0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
    tick();
    check_all("b_idle", 0, 32'hbfc00004, 32'h27bdffe8, 0, 0, 0, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
